// File: rtl/rk_pkg.sv
// rk_pkg: shared constants for the Radio-86RK CRT row supplier
package rk_pkg;
  localparam int H_VIS_D     = 64;
  localparam int ROW_LINES_D = 10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ATTR_TAG   = 2'b10;
  localparam int         ATTR_RVV   = 4;
  localparam int         ATTR_BLINK = 1;
  localparam int         ATTR_UL    = 0;
endpackage

// File: rtl/rk_crt_rowbuf.sv
// rk_crt_rowbuf: ping-pong pair of character row buffers, one write and one async read port
module rk_crt_rowbuf
  import rk_pkg::*;
#(
  parameter int DEPTH = H_VIS_D,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk50mhz,
  input  logic          we,
  input  logic          wsel,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          rsel,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2][DEPTH];
  // DMA bytes land in the buffer currently being filled
  always_ff @(posedge clk50mhz)
    if (we) mem[wsel][waddr] <= wdata;
  assign rdata = mem[rsel][raddr];
endmodule

// File: rtl/rk_crt.sv
// rk_crt: Radio-86RK character-row supplier, simplified i8275 display side
module rk_crt
  import rk_pkg::*;
#(
  parameter int H_LEFT    = 8,
  parameter int H_VIS     = H_VIS_D,
  parameter int V_TOP     = 30,
  parameter int ROW_LINES = ROW_LINES_D,
  parameter int ROWS_VIS  = 30,
  parameter int CUR_LINE  = 9
) (
  input  logic       clk50mhz,
  input  logic       rst_n,
  input  logic       cce,
  input  logic       hr,
  input  logic       vr,
  output logic       drq,
  input  logic       dack,
  input  logic [7:0] din,
  output logic       frame_start,
  input  logic [6:0] cursor_col,
  input  logic [4:0] cursor_row,
  output logic [6:0] ichar,
  output logic [3:0] line,
  output logic       vsp,
  output logic       lten,
  output logic       rvv,
  output logic       underrun
);
  localparam int AW = $clog2(H_VIS);
  localparam logic [6:0]  HL = 7'(H_LEFT);
  localparam logic [6:0]  HE = 7'(H_LEFT + H_VIS);
  localparam logic [AW:0] PF = (AW+1)'(H_VIS);
  localparam logic [AW:0] PL = (AW+1)'(H_VIS - 1);
  localparam logic [7:0]  VT = 8'(V_TOP - 1);
  localparam logic [3:0]  LL = 4'(ROW_LINES - 1);
  localparam logic [3:0]  CL = 4'(CUR_LINE);
  localparam logic [4:0]  RV = 5'(ROWS_VIS);

  logic [2:0]  hr_q, vr_q;
  logic        hr_fall, vr_fall;
  logic [4:0]  fcnt;
  logic        active;
  logic [7:0]  vcnt;
  logic [3:0]  lcnt;
  logic [4:0]  row, row_nx;
  logic        wrap, swap;
  logic [1:0]  st;
  logic [AW:0] ptr;
  logic        fsel, dsel, dbad, wr;
  logic [6:0]  ccnt, col;
  logic [7:0]  b;
  logic        in_rows, vis, attr, first;
  logic        rvv_f, blink_f, ul_f, rv_o, bl_o, ul_o;

  rk_crt_rowbuf #(.DEPTH(H_VIS)) u_buf (
    .clk50mhz(clk50mhz),
    .we      (wr),
    .wsel    (fsel),
    .waddr   (ptr[AW-1:0]),
    .wdata   (din),
    .rsel    (dsel),
    .raddr   (col[AW-1:0]),
    .rdata   (b)
  );

  // Edge detects, row stepping and the current character's attribute context
  always_comb begin
    hr_fall = hr_q[2] & ~hr_q[1];
    vr_fall = vr_q[2] & ~vr_q[1];
    row_nx  = active ? row + {4'd0, row != RV} : 5'd0;
    wrap    = hr_fall && (active ? lcnt == LL : vcnt == VT);
    swap    = wrap && row_nx < RV;
    wr      = dack && st == ST_FILL;
    drq     = st == ST_FILL;
    col     = ccnt - HL;
    in_rows = active && row < RV;
    vis     = in_rows && !dbad && ccnt >= HL && ccnt < HE;
    attr    = b[7:6] == ATTR_TAG;
    first   = col == 7'd0;
    rv_o    = rvv_f & ~first;
    bl_o    = blink_f & ~first;
    ul_o    = ul_f & ~first;
  end

  // Two-flop synchronisers plus one history flop for the sync edge detectors
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      hr_q <= 3'b111;
      vr_q <= 3'b111;
    end else begin
      hr_q <= {hr_q[1:0], hr};
      vr_q <= {vr_q[1:0], vr};
    end

  // Frame pulse and frame counter driving blink/cursor phases
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      frame_start <= 1'b0;
      fcnt        <= 5'd0;
    end else begin
      frame_start <= vr_fall;
      fcnt        <= fcnt + 5'(vr_fall);
    end

  // Vertical position: top margin count, then line-in-row and row index
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      active <= 1'b0;
      vcnt   <= 8'd0;
      lcnt   <= 4'd0;
      row    <= 5'd0;
    end else if (vr_fall) begin
      active <= 1'b0;
      vcnt   <= 8'd0;
      lcnt   <= 4'd0;
      row    <= 5'd0;
    end else if (hr_fall) begin
      if (wrap) begin
        active <= 1'b1;
        lcnt   <= 4'd0;
        row    <= row_nx;
      end else if (active) lcnt <= lcnt + 4'd1;
      else vcnt <= vcnt + 8'd1;
    end

  // Fill FSM: collects one row ahead via DMA and swaps buffers at each row start
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      st       <= ST_IDLE;
      ptr      <= '0;
      fsel     <= 1'b0;
      dsel     <= 1'b0;
      dbad     <= 1'b1;
      underrun <= 1'b0;
    end else if (vr_fall) begin
      st       <= ST_FILL;
      ptr      <= '0;
      fsel     <= 1'b0;
      dbad     <= 1'b1;
      underrun <= 1'b0;
    end else if (swap) begin
      st       <= row_nx + 5'd1 < RV ? ST_FILL : ST_IDLE;
      ptr      <= '0;
      fsel     <= ~fsel;
      dsel     <= fsel;
      dbad     <= ptr != PF;
      underrun <= underrun | (ptr != PF);
    end else if (wr) begin
      ptr <= ptr + 1'b1;
      st  <= ptr == PL ? ST_FULL : ST_FILL;
    end

  // Character stage: one cce in, registered character/attribute outputs next clock
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      ccnt    <= 7'd0;
      rvv_f   <= 1'b0;
      blink_f <= 1'b0;
      ul_f    <= 1'b0;
      ichar   <= 7'd0;
      line    <= 4'd0;
      vsp     <= 1'b1;
      lten    <= 1'b0;
      rvv     <= 1'b0;
    end else begin
      if (hr_fall) ccnt <= 7'd0;
      else if (cce && ccnt != HE) ccnt <= ccnt + 7'd1;
      if (cce) begin
        if (vis) {rvv_f, blink_f, ul_f} <= attr ? {b[ATTR_RVV], b[ATTR_BLINK], b[ATTR_UL]} : {rv_o, bl_o, ul_o};
        line  <= in_rows ? lcnt : 4'd0;
        ichar <= vis && !b[7] ? b[6:0] : 7'd0;
        vsp   <= !vis || b[7] || (bl_o && fcnt[4]);
        rvv   <= vis && rv_o;
        lten  <= vis && lcnt == CL && (ul_o || (col == cursor_col && row == cursor_row && fcnt[3]));
      end
    end
endmodule

// File: tb/tb_rk_crt.sv
// tb_rk_crt: randomized scoreboard bench for the CRT row supplier
module tb_rk_crt;
  logic       clk50mhz = 1'b0;
  logic       rst_n = 1'b0, cce = 1'b0, hr = 1'b1, vr = 1'b1, dack = 1'b0;
  logic [7:0] din = 8'd0;
  logic [6:0] cursor_col = 7'd5;
  logic [4:0] cursor_row = 5'd2;
  logic       drq, frame_start, vsp, lten, rvv, underrun;
  logic [6:0] ichar;
  logic [3:0] line;
  int checks = 0, errors = 0;
  int fc = 0, k = 0, ccnt = 0, issued = 0, cap = 999, mode = 0;
  bit framed = 0, fill_on = 0, dbad = 1, und = 0;
  logic [7:0]  fillq[$], disp[$];
  logic [13:0] expq[$];
  logic        pend = 1'b0;

  always #10 clk50mhz = ~clk50mhz;

  rk_crt dut (
    .clk50mhz   (clk50mhz),
    .rst_n      (rst_n),
    .cce        (cce),
    .hr         (hr),
    .vr         (vr),
    .drq        (drq),
    .dack       (dack),
    .din        (din),
    .frame_start(frame_start),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .ichar      (ichar),
    .line       (line),
    .vsp        (vsp),
    .lten       (lten),
    .rvv        (rvv),
    .underrun   (underrun)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (frame %0d hr %0d cce %0d)", nm, act, exp, fc, k, ccnt);
    end
  endtask

  // Expected {ichar,line,vsp,lten,rvv} for the c-th cce after the latest hr fall
  function automatic logic [13:0] model_out(int c);
    int rw, ln, col;
    logic rv, bl, ul;
    logic [7:0] b;
    if (!framed || k < 30 || (k - 30) / 10 >= 30) return 14'b100;
    rw  = (k - 30) / 10;
    ln  = (k - 30) % 10;
    col = c - 8;
    if (col < 0 || col >= 64 || dbad) return {7'd0, 4'(ln), 3'b100};
    {rv, bl, ul} = 3'b000;
    for (int j = 0; j < col; j++)
      if (disp[j][7:6] == 2'b10) {rv, bl, ul} = {disp[j][4], disp[j][1], disp[j][0]};
    b = disp[col];
    return {b[7] ? 7'd0 : b[6:0], 4'(ln), b[7] | (bl & fc[4]),
            ln == 9 && (ul || (col == int'(cursor_col) && rw == int'(cursor_row) && fc[3])), rv};
  endfunction

  function automatic logic [7:0] gen();
    int r = $urandom_range(7);
    if (mode == 0) return 8'h41;
    if (mode == 2) return fillq.size() == 0 ? 8'h90 : 8'h42;
    return r < 5 ? {1'b0, 7'($urandom)} : r < 7 ? {2'b10, 6'($urandom)} : {2'b11, 6'($urandom)};
  endfunction

  task automatic reset_checks();
    check("rst_drq", drq, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_ichar", ichar, 0);
    check("rst_line", line, 0);
    check("rst_vsp", vsp, 1);
    check("rst_lten", lten, 0);
    check("rst_rvv", rvv, 0);
    check("rst_underrun", underrun, 0);
  endtask

  task automatic vr_pulse();
    int n = 0;
    vr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk50mhz);
      n += int'(frame_start);
    end
    vr = 1'b1;
    repeat (3) @(negedge clk50mhz);
    fc = (fc + 1) % 32;
    framed = 1; k = 0; fill_on = 1; fillq = {}; issued = 0; und = 0; dbad = 1;
    check("frame_start_len", n, 1);
    check("drq_after_vr", drq, 1);
    check("underrun_after_vr", underrun, 0);
  endtask

  task automatic hr_pulse();
    hr = 1'b0;
    repeat (4) @(negedge clk50mhz);
    hr = 1'b1;
    repeat (4) @(negedge clk50mhz);
    k++;
    ccnt = 0;
    if (framed && k >= 30 && (k - 30) % 10 == 0 && (k - 30) / 10 < 30) begin
      dbad = fillq.size() != 64;
      und |= dbad;
      if (!dbad) disp = fillq;
      fillq = {};
      fill_on = (k - 30) / 10 + 1 < 30;
      issued = 0;
      cap = 999;
    end
  endtask

  task automatic scan(input int ncce, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      check("drq", drq, fill_on && fillq.size() < 64);
      cce  = c < ncce;
      dack = issued < cap && $urandom_range(1) == 1;
      din  = gen();
      if (cce) begin
        expq.push_back(model_out(ccnt));
        ccnt++;
      end
      if (dack) begin
        issued++;
        if (fill_on && fillq.size() < 64) fillq.push_back(din);
      end
      @(negedge clk50mhz);
    end
    cce = 1'b0;
    dack = 1'b0;
    check("underrun", underrun, und);
  endtask

  task automatic frame(input int m, input int rows, input int cp);
    mode = m;
    cap = cp;
    vr_pulse();
    scan(0, 8);
    for (int l = 1; l < 30 + rows * 10; l++) begin
      hr_pulse();
      scan(l < 30 ? 2 : 76, l < 30 ? 8 : 80);
    end
  endtask

  always @(posedge clk50mhz) pend <= cce;

  always @(negedge clk50mhz)
    if (pend) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL char_out: output %0h with no expected entry", {ichar, line, vsp, lten, rvv});
      end else check("char_out", {ichar, line, vsp, lten, rvv}, expq.pop_front());
    end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk50mhz);
    reset_checks();
    rst_n = 1'b1;
    @(negedge clk50mhz);
    reset_checks();
    frame(0, 2, 999);
    frame(0, 2, 40);
    frame(2, 2, 999);
    repeat (5) vr_pulse();
    frame(1, 3, 999);
    repeat (10) vr_pulse();
    frame(1, 3, 999);
    repeat (6) vr_pulse();
    frame(1, 3, 999);
    mode = 1;
    cap = 999;
    vr_pulse();
    scan(0, 8);
    for (int l = 1; l < 10; l++) begin
      hr_pulse();
      scan(2, 8);
    end
    rst_n = 1'b0;
    @(negedge clk50mhz);
    reset_checks();
    framed = 0; fc = 0; fill_on = 0; und = 0; fillq = {};
    repeat (3) @(negedge clk50mhz);
    rst_n = 1'b1;
    scan(4, 16);
    frame(1, 2, 999);
    repeat (2) @(negedge clk50mhz);
    check("queue_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
